// File: rtl/led_sequencer.sv
// led_sequencer: command-driven owner of the 8-bit GPIO LED bank.
// Accepts one OFF/STATIC/BLINK/CHASE command over valid/ready and steps
// the pattern on a prescaled tick. Single clock domain, sync active-high reset.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no command active; LEDs hold last value; ready for a command
//   RUN   | BLINK/CHASE stepping on ticks; preemptible only if continuous
//   DONE  | one-cycle completion pulse; LEDs hold; not ready
module led_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 27
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [7:0] cmd_pattern,
    input  logic [3:0] cmd_repeat,
    output logic       busy,
    output logic       done,
    output logic [7:0] gpio_led
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0]       LP_MODE_OFF = 2'b00;
    localparam logic [1:0]       LP_MODE_BLINK = 2'b10;
    localparam logic [CNT_W-1:0] LP_TICK_TC = CNT_W'(TICK_DIV - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_mode;
    logic [7:0]       r_pattern;
    logic [3:0]       r_repeat;
    logic [3:0]       r_steps_left;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_led;

    logic w_ready;
    logic w_accept;
    logic w_tick;
    logic w_last_step;

    // Handshake and tick decode; ready depends on state, never on cmd_valid
    always_comb begin
        w_ready     = (r_state == S_IDLE) || ((r_state == S_RUN) && (r_repeat == 4'd0));
        w_accept    = cmd_valid && w_ready;
        w_tick      = (r_state == S_RUN) && (r_cnt == LP_TICK_TC);
        w_last_step = w_tick && (r_repeat != 4'd0) && (r_steps_left == 4'd1);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an accept always wins over a coincident tick
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_RUN: begin
                if (w_accept) begin
                    w_state_nxt = cmd_mode[1] ? S_RUN : S_DONE;
                end else if ((r_state == S_RUN) && w_last_step) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        cmd_ready = w_ready;
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        gpio_led  = r_led;
    end

    // Command latch, tick prescaler, step counter and LED register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mode       <= LP_MODE_OFF;
            r_pattern    <= 8'h00;
            r_repeat     <= 4'd0;
            r_steps_left <= 4'd0;
            r_cnt        <= '0;
            r_led        <= 8'h00;
        end else if (w_accept) begin
            r_mode       <= cmd_mode;
            r_pattern    <= cmd_pattern;
            r_repeat     <= cmd_repeat;
            r_steps_left <= cmd_repeat;
            r_cnt        <= '0;
            r_led        <= (cmd_mode == LP_MODE_OFF) ? 8'h00 : cmd_pattern;
        end else if (r_state == S_RUN) begin
            if (w_tick) begin
                r_cnt <= '0;
                if (r_mode == LP_MODE_BLINK) begin
                    r_led <= (r_led == 8'h00) ? r_pattern : 8'h00;
                end else begin
                    r_led <= {r_led[6:0], r_led[7]};
                end
                if (r_repeat != 4'd0) begin
                    r_steps_left <= r_steps_left - 4'd1;
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
